// File: rtl/intt_pkg.sv
// Shared INTT/NTT sequencing definitions: default sizes, FSM encoding and
// Gentleman-Sande butterfly index mapping.
package intt_pkg;

  localparam int unsigned LOG_N_DEF = 8;
  localparam int unsigned N         = 1 << LOG_N_DEF;
  localparam int unsigned WB_DELAY  = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } intt_state_t;

  // Upper-half-free address of butterfly c in stage s: group g = c>>s, offset k = c&(t-1).
  function automatic int unsigned bf_addr_a(input int unsigned s, input int unsigned c);
    int unsigned t;
    t = 32'd1 << s;
    return ((c >> s) << (s + 32'd1)) | (c & (t - 32'd1));
  endfunction

  function automatic int unsigned bf_addr_b(input int unsigned s, input int unsigned c);
    return bf_addr_a(s, c) | (32'd1 << s);
  endfunction

  // Bit-reversed twiddle table: stage s uses entries h..2h-1 with h = N>>(s+1).
  function automatic int unsigned bf_twiddle(input int unsigned log_n, input int unsigned s,
                                             input int unsigned c);
    return ((32'd1 << log_n) >> (s + 32'd1)) + (c >> s);
  endfunction

endpackage

// File: rtl/intt_stage_sequencer_if.sv
// Control/address bus between the INTT stage sequencer and the RAM/ROM/butterfly datapath.
interface intt_stage_sequencer_if #(
  parameter int unsigned LOG_N = 8
);
  logic             start;
  logic             busy;
  logic             done;
  logic [LOG_N-1:0] stage;
  logic             rd_en;
  logic [LOG_N-1:0] rd_addr_a;
  logic [LOG_N-1:0] rd_addr_b;
  logic [LOG_N-1:0] tw_addr;
  logic             wr_en;
  logic [LOG_N-1:0] wr_addr_a;
  logic [LOG_N-1:0] wr_addr_b;

  modport master (
    input  start,
    output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
    output wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    output start,
    input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
    input  wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/intt_wb_delay.sv
// DEPTH-stage delay line with a valid lane; data stages only load on valid so
// the output holds the last valid word.
module intt_wb_delay #(
  parameter int unsigned DEPTH = 7,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < int'(DEPTH); i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      if (in_valid) dat[0] <= in_data;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/intt_stage_sequencer.sv
// Walks all LOG_N Gentleman-Sande stages: issues read/twiddle addresses one
// butterfly per cycle and replays them as write-back addresses WB cycles later.
module intt_stage_sequencer
  import intt_pkg::*;
#(
  parameter int unsigned LOG_N       = $clog2(N),
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned BF_LATENCY  = WB_DELAY - 1
) (
  input logic                    clk,
  input logic                    rst,
  intt_stage_sequencer_if.master bus
);

  localparam int unsigned N_PTS  = 1 << LOG_N;
  localparam int unsigned WB     = MEM_LATENCY + BF_LATENCY;
  localparam int unsigned DCNT_W = (WB > 1) ? $clog2(WB) : 1;

  localparam logic [LOG_N-1:0]  C_LAST = LOG_N'(N_PTS / 2 - 1);
  localparam logic [LOG_N-1:0]  S_LAST = LOG_N'(LOG_N - 1);
  localparam logic [DCNT_W-1:0] D_LAST = DCNT_W'(WB - 1);

  intt_state_t       state;
  logic [LOG_N-1:0]  s;
  logic [LOG_N-1:0]  c;
  logic [DCNT_W-1:0] dcnt;

  logic             busy, done, rd_en;
  logic [LOG_N-1:0] stage, rd_addr_a, rd_addr_b, tw_addr;

  int unsigned      iss_s, iss_c;
  logic [LOG_N-1:0] iss_a, iss_b, iss_tw;

  // Coordinates of the butterfly that the next issuing edge will present.
  always_comb begin
    iss_s = 32'(s);
    iss_c = 32'(c) + 32'd1;
    if (state == ST_IDLE) begin
      iss_s = 32'd0;
      iss_c = 32'd0;
    end else if (state == ST_DRAIN) begin
      iss_s = 32'(s) + 32'd1;
      iss_c = 32'd0;
    end
    iss_a  = LOG_N'(bf_addr_a(iss_s, iss_c));
    iss_b  = LOG_N'(bf_addr_b(iss_s, iss_c));
    iss_tw = LOG_N'(bf_twiddle(LOG_N, iss_s, iss_c));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      s         <= '0;
      c         <= '0;
      dcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stage     <= '0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            state     <= ST_ISSUE;
            s         <= '0;
            c         <= '0;
            busy      <= 1'b1;
            stage     <= '0;
            rd_en     <= 1'b1;
            rd_addr_a <= iss_a;
            rd_addr_b <= iss_b;
            tw_addr   <= iss_tw;
          end
        end
        ST_ISSUE: begin
          if (c == C_LAST) begin
            state <= ST_DRAIN;
            dcnt  <= '0;
            rd_en <= 1'b0;
          end else begin
            c         <= c + 1'b1;
            rd_addr_a <= iss_a;
            rd_addr_b <= iss_b;
            tw_addr   <= iss_tw;
          end
        end
        ST_DRAIN: begin
          // Last write of the stage lands in the final drain cycle, so the next stage reads safely.
          if (dcnt == D_LAST) begin
            if (s == S_LAST) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= ST_ISSUE;
              s         <= s + 1'b1;
              c         <= '0;
              stage     <= s + 1'b1;
              rd_en     <= 1'b1;
              rd_addr_a <= iss_a;
              rd_addr_b <= iss_b;
              tw_addr   <= iss_tw;
            end
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          stage <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic                 wr_valid;
  logic [2*LOG_N-1:0]   wr_data;

  intt_wb_delay #(
    .DEPTH(WB),
    .WIDTH(2 * LOG_N)
  ) u_wb_delay (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_en),
    .in_data  ({rd_addr_a, rd_addr_b}),
    .out_valid(wr_valid),
    .out_data (wr_data)
  );

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.stage     = stage;
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr_a = rd_addr_a;
  assign bus.rd_addr_b = rd_addr_b;
  assign bus.tw_addr   = tw_addr;
  assign bus.wr_en     = wr_valid;
  assign bus.wr_addr_a = wr_data[2*LOG_N-1:LOG_N];
  assign bus.wr_addr_b = wr_data[LOG_N-1:0];

endmodule
